ws2812_frame_ctrl: RTL and testbench

Double-buffered frame controller in front of the WS2812 serializer.
- Owns two pixel banks and lets the host fill the back bank while the serializer reads the front bank.
- Swaps banks only at a serializer frame boundary, so a strip never shows a torn frame.
- Provides blanking, a frame counter and a stall watchdog.

---
 rtl/ws2812_pkg.sv | 24 ++
 rtl/ws2812_pixel_ram.sv | 29 ++
 rtl/ws2812_frame_ctrl.sv | 124 ++++++++++++
 tb/tb_ws2812_frame_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812 frame controller and serializer:
// swap FSM encoding, RGB packing offsets and default line timing.
package ws2812_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SWAP_PEND = 2'd1,
        ST_DONE      = 2'd2
    } frame_state_e;

    localparam int RGB_W = 24;
    localparam int R_OFS = 16;
    localparam int G_OFS = 8;
    localparam int B_OFS = 0;

    // 1.25 us bit period and >50 us reset symbol at a 50 MHz clock.
    localparam int CYCLES_PER_BIT_DEF = 63;
    localparam int RESET_CYCLES_DEF   = 2500;

    function automatic logic [7:0] rgb_chan(input logic [RGB_W-1:0] rgb, input int ofs);
        return rgb[ofs +: 8];
    endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
// No read-during-write ordering is promised between the two ports.
module ws2812_pixel_ram #(
    parameter int AW = 10,
    parameter int DW = 24
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// Double-buffered frame controller: host fills the back bank, the serializer
// reads the front bank, and banks swap only on a serializer frame end.
module ws2812_frame_ctrl
    import ws2812_pkg::*;
#(
    parameter int LED_COUNT    = 300,
    parameter int ADDR_W       = 9,
    parameter int STALL_CYCLES = 5000000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              host_we_i,
    input  logic [ADDR_W-1:0] host_addr_i,
    input  logic [23:0]       host_rgb_i,
    input  logic              host_swap_req_i,
    output logic              host_swap_pend_o,
    output logic              host_swap_done_o,
    input  logic              blank_i,
    input  logic [ADDR_W-1:0] drv_addr_i,
    input  logic              drv_frame_end_i,
    output logic [7:0]        drv_r_o,
    output logic [7:0]        drv_g_o,
    output logic [7:0]        drv_b_o,
    output logic              front_bank_o,
    output logic [15:0]       frame_count_o,
    output logic              stall_o
);

    localparam int                CNT_W     = $clog2(STALL_CYCLES + 1);
    localparam logic [CNT_W-1:0]  STALL_MAX = CNT_W'(STALL_CYCLES);
    localparam logic [ADDR_W:0]   LED_LIM   = (ADDR_W + 1)'(LED_COUNT);

    frame_state_e       state_q;
    logic               front_bank_q;
    logic               pend_q;
    logic               done_q;
    logic               stall_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [15:0]        frame_cnt_q;
    logic               rd_ok_q;

    logic               wr_en;
    logic               drv_in_range;
    logic [RGB_W-1:0]   ram_rdata;

    assign wr_en        = host_we_i && ({1'b0, host_addr_i} < LED_LIM);
    assign drv_in_range = {1'b0, drv_addr_i} < LED_LIM;

    // The write bank uses the pre-swap front bank, so a write on the swap
    // edge lands in the bank that becomes visible on that same edge.
    ws2812_pixel_ram #(
        .AW (ADDR_W + 1),
        .DW (RGB_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .waddr_i ({~front_bank_q, host_addr_i}),
        .wdata_i (host_rgb_i),
        .raddr_i ({front_bank_q, drv_addr_i}),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            front_bank_q <= 1'b0;
            pend_q       <= 1'b0;
            done_q       <= 1'b0;
            stall_q      <= 1'b0;
            stall_cnt_q  <= '0;
            frame_cnt_q  <= 16'd0;
            rd_ok_q      <= 1'b0;
        end else begin
            rd_ok_q <= !blank_i && drv_in_range;
            done_q  <= 1'b0;
            if (drv_frame_end_i) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (host_swap_req_i) begin
                        state_q     <= ST_SWAP_PEND;
                        pend_q      <= 1'b1;
                        stall_cnt_q <= '0;
                    end
                end
                ST_SWAP_PEND: begin
                    if (drv_frame_end_i) begin
                        front_bank_q <= ~front_bank_q;
                        pend_q       <= 1'b0;
                        done_q       <= 1'b1;
                        state_q      <= ST_DONE;
                    end else begin
                        if (stall_cnt_q != STALL_MAX) begin
                            stall_cnt_q <= stall_cnt_q + 1'b1;
                        end
                        if (stall_cnt_q >= STALL_MAX - 1'b1) begin
                            stall_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // The RAM read register carries no reset; the registered mask keeps the
    // pixel outputs at zero through reset, blanking and out-of-range reads.
    assign drv_r_o = rd_ok_q ? rgb_chan(ram_rdata, R_OFS) : 8'd0;
    assign drv_g_o = rd_ok_q ? rgb_chan(ram_rdata, G_OFS) : 8'd0;
    assign drv_b_o = rd_ok_q ? rgb_chan(ram_rdata, B_OFS) : 8'd0;

    assign front_bank_o     = front_bank_q;
    assign host_swap_pend_o = pend_q;
    assign host_swap_done_o = done_q;
    assign stall_o          = stall_q;
    assign frame_count_o    = frame_cnt_q;

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Directed bench for ws2812_frame_ctrl: table of read/write vectors plus
// hand-written swap, stall, async-reset, blanking and frame-counter sequences.
module tb_ws2812_frame_ctrl;

    localparam int LED_COUNT    = 300;
    localparam int ADDR_W       = 9;
    localparam int STALL_CYCLES = 20;

    logic              clk;
    logic              rst_n;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [23:0]       wrgb;
    logic              req;
    logic              pend;
    logic              done;
    logic              blank;
    logic [ADDR_W-1:0] daddr;
    logic              fend;
    logic [7:0]        r, g, b;
    logic              front;
    logic [15:0]       frames;
    logic              stall;

    int n_cmp = 0;
    int n_err = 0;

    ws2812_frame_ctrl #(
        .LED_COUNT    (LED_COUNT),
        .ADDR_W       (ADDR_W),
        .STALL_CYCLES (STALL_CYCLES)
    ) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .host_we_i        (we),
        .host_addr_i      (waddr),
        .host_rgb_i       (wrgb),
        .host_swap_req_i  (req),
        .host_swap_pend_o (pend),
        .host_swap_done_o (done),
        .blank_i          (blank),
        .drv_addr_i       (daddr),
        .drv_frame_end_i  (fend),
        .drv_r_o          (r),
        .drv_g_o          (g),
        .drv_b_o          (b),
        .front_bank_o     (front),
        .frame_count_o    (frames),
        .stall_o          (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] waddr;
        logic [23:0]       wrgb;
        logic              blank;
        logic [ADDR_W-1:0] daddr;
        logic [23:0]       exp_rgb;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [23:0] d);
        we = 1'b1; waddr = a; wrgb = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [ADDR_W-1:0] a, input logic [23:0] exp);
        daddr = a;
        tick();
        chk(name, {8'd0, r, g, b}, {8'd0, exp});
    endtask

    initial begin
        int dones;
        int toggles;
        logic prev_front;

        vecs[0] = '{1'b0, 9'd0,   24'h000000, 1'b0, 9'd5,   24'h112233};
        vecs[1] = '{1'b1, 9'd5,   24'hAABBCC, 1'b0, 9'd5,   24'h112233};
        vecs[2] = '{1'b0, 9'd0,   24'h000000, 1'b0, 9'd0,   24'h010203};
        vecs[3] = '{1'b0, 9'd0,   24'h000000, 1'b0, 9'd299, 24'h0A0B0C};
        vecs[4] = '{1'b0, 9'd0,   24'h000000, 1'b0, 9'd300, 24'h000000};
        vecs[5] = '{1'b0, 9'd0,   24'h000000, 1'b0, 9'd511, 24'h000000};
        vecs[6] = '{1'b0, 9'd0,   24'h000000, 1'b1, 9'd5,   24'h000000};
        vecs[7] = '{1'b0, 9'd0,   24'h000000, 1'b0, 9'd5,   24'h112233};
        vecs[8] = '{1'b1, 9'd300, 24'hFFFFFF, 1'b0, 9'd299, 24'h0A0B0C};

        rst_n = 1'b0; we = 1'b0; waddr = '0; wrgb = '0; req = 1'b0;
        blank = 1'b0; daddr = '0; fend = 1'b0;

        tick(); tick();
        chk("reset_drv", {8'd0, r, g, b}, 32'd0);
        chk("reset_front", {31'd0, front}, 32'd0);
        chk("reset_frames", {16'd0, frames}, 32'd0);
        chk("reset_pend_done_stall", {29'd0, pend, done, stall}, 32'd0);
        rst_n = 1'b1;

        // Fill the back bank (bank 1); out-of-range writes must vanish.
        wr(9'd5,   24'h112233);
        wr(9'd0,   24'h010203);
        wr(9'd299, 24'h0A0B0C);
        wr(9'd300, 24'hFFFFFF);
        wr(9'd511, 24'hEEEEEE);

        req = 1'b1; tick(); req = 1'b0;
        chk("swap1_pend", {31'd0, pend}, 32'd1);
        chk("swap1_front_before", {31'd0, front}, 32'd0);
        repeat (9) tick();
        chk("swap1_still_pend", {30'd0, pend, front}, 32'd2);
        fend = 1'b1; tick(); fend = 1'b0;
        chk("swap1_front_toggled", {31'd0, front}, 32'd1);
        chk("swap1_done_pulse", {30'd0, done, pend}, 32'd2);
        chk("swap1_frames", {16'd0, frames}, 32'd1);
        tick();
        chk("swap1_done_cleared", {30'd0, done, front}, 32'd1);

        for (int i = 0; i < 9; i++) begin
            we = vecs[i].we; waddr = vecs[i].waddr; wrgb = vecs[i].wrgb;
            blank = vecs[i].blank; daddr = vecs[i].daddr;
            tick();
            we = 1'b0; blank = 1'b0;
            chk($sformatf("vec%0d_addr%0d", i, vecs[i].daddr), {8'd0, r, g, b}, {8'd0, vecs[i].exp_rgb});
        end

        // Two requests three cycles apart, then a single frame end with a
        // write on the swap edge.
        req = 1'b1; tick(); req = 1'b0;
        tick(); tick();
        req = 1'b1; tick(); req = 1'b0;
        chk("dbl_req_pend", {30'd0, pend, front}, 32'd3);
        tick(); tick();
        prev_front = front;
        fend = 1'b1; we = 1'b1; waddr = 9'd9; wrgb = 24'h123456;
        tick();
        fend = 1'b0; we = 1'b0;
        dones = 0; toggles = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) dones++;
            if (front != prev_front) toggles++;
            prev_front = front;
            tick();
        end
        chk("dbl_req_done_count", dones, 32'd1);
        chk("dbl_req_toggle_count", toggles, 32'd1);
        chk("dbl_req_front", {30'd0, pend, front}, 32'd0);
        rd_chk("swap_edge_write", 9'd9, 24'h123456);
        rd_chk("bank0_addr5", 9'd5, 24'hAABBCC);

        // Request and frame end together: request taken, swap deferred.
        req = 1'b1; fend = 1'b1; tick(); req = 1'b0; fend = 1'b0;
        chk("simul_pend_front", {30'd0, pend, front}, 32'd2);
        chk("simul_frames", {16'd0, frames}, 32'd3);
        repeat (3) tick();
        fend = 1'b1; tick(); fend = 1'b0;
        chk("simul_swap", {30'd0, done, front}, 32'd3);
        tick();

        // Stall watchdog with front bank 1 showing pixel 5.
        daddr = 9'd5;
        req = 1'b1; tick(); req = 1'b0;
        repeat (STALL_CYCLES - 1) tick();
        chk("stall_before_limit", {30'd0, stall, pend}, 32'd1);
        tick();
        chk("stall_at_limit", {31'd0, stall}, 32'd1);
        repeat (5) tick();
        chk("stall_sticky", {29'd0, stall, pend, front}, 32'd7);
        chk("stall_frames", {16'd0, frames}, 32'd4);
        chk("stall_drv", {8'd0, r, g, b}, 32'h00112233);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_flags", {28'd0, front, pend, done, stall}, 32'd0);
        chk("async_rst_frames", {16'd0, frames}, 32'd0);
        chk("async_rst_drv", {8'd0, r, g, b}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // RAM survives reset; blanking masks on the next edge.
        rd_chk("post_rst_bank0", 9'd5, 24'hAABBCC);
        blank = 1'b1;
        tick();
        chk("blank_drv", {8'd0, r, g, b}, 32'd0);
        blank = 1'b0;

        fend = 1'b1;
        repeat (65535) tick();
        chk("frames_ffff", {16'd0, frames}, 32'h0000FFFF);
        tick();
        fend = 1'b0;
        chk("frames_wrap", {16'd0, frames}, 32'd0);
        tick();
        chk("frames_hold_front", {15'd0, front, frames}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
